wb_port_arbiter: RTL and testbench

Shares the register file's single write port between the in-order pipeline writeback stage and a long-latency unit (multiply/divide, late load return) whose results arrive out of band. Pipeline writes always win. Long-latency results queue in a small FIFO and drain into idle write slots. A pending-destination scoreboard drives decode-stage stalls for RAW/WAW hazards on registers with outstanding long-latency writes. Sits between writeback, the long-latency unit, the hazard unit and the register file.

---
 rtl/wb_pkg.sv | 12 +
 rtl/wb_port_arbiter_if.sv | 35 +++
 rtl/wb_fifo.sv | 48 ++++
 rtl/wb_port_arbiter.sv | 99 +++++++++
 tb/tb_wb_port_arbiter.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/wb_pkg.sv
// Shared types and constants for the register-file write-port arbiter.
package wb_pkg;

  localparam int REG_AW = 5;
  localparam int XLEN   = 32;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   wd;
  } entry_t;

endpackage

// File: rtl/wb_port_arbiter_if.sv
// Bus bundle between writeback, long-latency unit, hazard unit and register file.
interface wb_port_arbiter_if #(parameter int XLEN = wb_pkg::XLEN);

  logic                      p_we;
  logic [wb_pkg::REG_AW-1:0] p_wa;
  logic [XLEN-1:0]           p_wd;
  logic                      lu_issue;
  logic [wb_pkg::REG_AW-1:0] lu_issue_rd;
  logic                      lu_valid;
  logic [wb_pkg::REG_AW-1:0] lu_rd;
  logic [XLEN-1:0]           lu_wd;
  logic                      lu_ready;
  logic [wb_pkg::REG_AW-1:0] chk_ra1;
  logic [wb_pkg::REG_AW-1:0] chk_ra2;
  logic [wb_pkg::REG_AW-1:0] chk_rd;
  logic                      stall;
  logic                      drain_req;
  logic                      rf_we;
  logic [wb_pkg::REG_AW-1:0] rf_wa;
  logic [XLEN-1:0]           rf_wd;
  logic [31:0]               pending;

  modport slave (
    input  p_we, p_wa, p_wd, lu_issue, lu_issue_rd, lu_valid, lu_rd, lu_wd,
           chk_ra1, chk_ra2, chk_rd,
    output lu_ready, stall, drain_req, rf_we, rf_wa, rf_wd, pending
  );

  modport master (
    output p_we, p_wa, p_wd, lu_issue, lu_issue_rd, lu_valid, lu_rd, lu_wd,
           chk_ra1, chk_ra2, chk_rd,
    input  lu_ready, stall, drain_req, rf_we, rf_wa, rf_wd, pending
  );

endinterface

// File: rtl/wb_fifo.sv
// Circular buffer of DEPTH long-latency results; caller guarantees no push
// when full and no pop when empty.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  entry_t                     din,
  output entry_t                     head,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);

  entry_t        mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // Pointers are exactly log2(DEPTH) wide, so they wrap on their own.
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: the storage array has no reset; count and pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline writes win, long-latency results
// queue and drain into idle slots; optional same-cycle bypass under WB_BYPASS_EN.
module wb_port_arbiter
  import wb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int XLEN  = wb_pkg::XLEN
) (
  input logic               clk,
  input logic               rst,
  wb_port_arbiter_if.slave  bus
);

  localparam int CW = $clog2(DEPTH) + 1;

  if (XLEN != wb_pkg::XLEN) begin : g_xlen_guard
    $error("wb_port_arbiter: XLEN must match wb_pkg::XLEN");
  end

  logic [CW-1:0] count;
  entry_t        head;
  entry_t        din;
  logic          push;
  logic          pop;
  logic          accept;
  logic          bypass;
  logic          lu_ready;
  logic [31:0]   pending_q;
  logic [31:0]   set_mask;
  logic [31:0]   clr_mask;

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (din),
    .head  (head),
    .count (count)
  );

  assign lu_ready = !rst && (count < CW'(DEPTH));
  assign accept   = bus.lu_valid && lu_ready;
  assign din      = '{rd: bus.lu_rd, wd: bus.lu_wd};

`ifdef WB_BYPASS_EN
  assign bypass = accept && !bus.p_we && (count == '0) && (bus.lu_rd != '0);
`else
  assign bypass = 1'b0;
`endif

  // x0 results are accepted but never stored.
  assign push = accept && (bus.lu_rd != '0) && !bypass;

  // NOTE: every output of this block gets a default first, so no path leaves a latch behind.
  always_comb begin
    bus.rf_we = 1'b0;
    bus.rf_wa = '0;
    bus.rf_wd = '0;
    pop       = 1'b0;
    clr_mask  = '0;
    if (!rst) begin
      if (bus.p_we) begin
        bus.rf_we = 1'b1;
        bus.rf_wa = bus.p_wa;
        bus.rf_wd = bus.p_wd;
      end else if (bypass) begin
        bus.rf_we           = 1'b1;
        bus.rf_wa           = bus.lu_rd;
        bus.rf_wd           = bus.lu_wd;
        clr_mask[bus.lu_rd] = 1'b1;
      end else if (count != '0) begin
        pop                 = 1'b1;
        bus.rf_we           = 1'b1;
        bus.rf_wa           = head.rd;
        bus.rf_wd           = head.wd;
        clr_mask[head.rd]   = 1'b1;
      end
    end
  end

  always_comb begin
    set_mask = '0;
    if (bus.lu_issue && (bus.lu_issue_rd != '0)) set_mask[bus.lu_issue_rd] = 1'b1;
  end

  // Applying set after clear lets a fresh issue survive a same-cycle drain of that register.
  always_ff @(posedge clk) begin
    if (rst) pending_q <= '0;
    else     pending_q <= (pending_q & ~clr_mask) | set_mask;
  end

  assign bus.pending   = pending_q;
  assign bus.lu_ready  = lu_ready;
  assign bus.drain_req = !rst && (count == CW'(DEPTH));
  assign bus.stall     = !rst && (pending_q[bus.chk_ra1] | pending_q[bus.chk_ra2] |
                                  pending_q[bus.chk_rd]);

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench: stimulus queues expected register-file writes, a negedge
// monitor pops and compares every write the DUT presents.
module tb_wb_port_arbiter;

`ifdef WB_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;
  logic [36:0] exp_q[$];

  always #5 clk = ~clk;

  wb_port_arbiter_if #(.XLEN(32)) bus ();

  wb_port_arbiter #(.DEPTH(4), .XLEN(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.p_we = 0; bus.p_wa = 0; bus.p_wd = 0;
    bus.lu_issue = 0; bus.lu_issue_rd = 0;
    bus.lu_valid = 0; bus.lu_rd = 0; bus.lu_wd = 0;
    bus.chk_ra1 = 0; bus.chk_ra2 = 0; bus.chk_rd = 0;
  endtask

  task automatic pipe(input logic [4:0] wa, input logic [31:0] wd);
    bus.p_we = 1; bus.p_wa = wa; bus.p_wd = wd;
    exp_q.push_back({wa, wd});
  endtask

  task automatic lu(input logic [4:0] rd, input logic [31:0] wd);
    bus.lu_valid = 1; bus.lu_rd = rd; bus.lu_wd = wd;
  endtask

  // Monitor: every register-file write must match the next queued expectation.
  initial begin
    logic [36:0] e;
    forever begin
      @(negedge clk);
      if (bus.rf_we) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_write: got wa=%0d wd=%h expected no write", bus.rf_wa, bus.rf_wd);
        end else begin
          e = exp_q.pop_front();
          check("rf_write", {27'd0, bus.rf_wa, bus.rf_wd}, {27'd0, e});
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1;
    idle();
    bus.chk_ra1 = 5;
    repeat (2) tick();
    @(negedge clk);
    check("rst_rf_we", bus.rf_we, 0);
    check("rst_lu_ready", bus.lu_ready, 0);
    check("rst_stall", bus.stall, 0);
    check("rst_drain_req", bus.drain_req, 0);
    tick(); rst = 0;
    @(negedge clk);
    check("post_rst_pending", bus.pending, 0);
    check("post_rst_lu_ready", bus.lu_ready, 1);

    // Basic issue / result / clear.
    tick(); bus.lu_issue = 1; bus.lu_issue_rd = 5;
    @(negedge clk);
    check("t1_stall_issue_cycle", bus.stall, 0);
    tick(); bus.lu_issue = 0; lu(5, 32'hDEADBEEF);
    exp_q.push_back({5'd5, 32'hDEADBEEF});
    @(negedge clk);
    check("t1_pending5", bus.pending, 32'h0000_0020);
    check("t1_stall_set", bus.stall, 1);
    check("t1_rf_we_accept_cycle", bus.rf_we, BYP);
    tick(); bus.lu_valid = 0;
    @(negedge clk);
    check("t1_stall_after_accept", bus.stall, !BYP);
    tick();
    @(negedge clk);
    check("t1_stall_clear", bus.stall, 0);
    check("t1_pending_clear", bus.pending, 0);

    // Pipeline hogs the port while the FIFO fills, then releases.
    tick(); bus.chk_ra1 = 0;
    for (int i = 0; i < 4; i++) begin
      pipe(5'(10 + i), 32'h1000 + i);
      lu(5'(11 + i), 32'hA0 + i);
      @(negedge clk);
      check("t2_lu_ready_fill", bus.lu_ready, 1);
      tick();
    end
    pipe(5'd14, 32'h1004);
    lu(5'd15, 32'hFF);
    @(negedge clk);
    check("t2_lu_ready_full", bus.lu_ready, 0);
    check("t2_drain_req_full", bus.drain_req, 1);
    tick();
    idle();
    for (int i = 0; i < 4; i++) exp_q.push_back({5'(11 + i), 32'hA0 + i});
    @(negedge clk);
    check("t2_lu_ready_full_pop", bus.lu_ready, 0);
    repeat (4) tick();
    @(negedge clk);
    check("t2_lu_ready_drained", bus.lu_ready, 1);
    check("t2_drain_req_drained", bus.drain_req, 0);

    // Pipeline write beats a pending head pop.
    tick(); pipe(5'd2, 32'h22); lu(5'd20, 32'h55);
    tick(); pipe(5'd3, 32'h33); bus.lu_valid = 0;
    @(negedge clk);
    check("t3_pipe_wins", bus.rf_wa, 3);
    tick(); idle(); exp_q.push_back({5'd20, 32'h55});
    @(negedge clk);
    check("t3_head_next", bus.rf_wa, 20);

    // x0 result is swallowed without occupying a slot.
    tick(); pipe(5'd4, 32'h44); lu(5'd21, 32'h66);
    tick(); pipe(5'd6, 32'h46); lu(5'd0, 32'h77);
    @(negedge clk);
    check("t4_x0_lu_ready", bus.lu_ready, 1);
    tick(); idle(); exp_q.push_back({5'd21, 32'h66});
    tick();
    @(negedge clk);
    check("t4_no_x0_write", bus.rf_we, 0);

    // Re-issue of rd=7 in the drain cycle of the older rd=7 keeps it pending.
    tick(); bus.lu_issue = 1; bus.lu_issue_rd = 7;
    tick(); bus.lu_issue = 0; pipe(5'd8, 32'h88); lu(5'd7, 32'h700);
    tick(); idle(); bus.lu_issue = 1; bus.lu_issue_rd = 7; bus.chk_rd = 7;
    exp_q.push_back({5'd7, 32'h700});
    @(negedge clk);
    check("t5_drain_rd7", bus.rf_wa, 7);
    tick(); bus.lu_issue = 0; lu(5'd7, 32'h701);
    exp_q.push_back({5'd7, 32'h701});
    @(negedge clk);
    check("t5_pending7_kept", bus.pending[7], 1);
    check("t5_stall_rd7", bus.stall, 1);
    tick(); bus.lu_valid = 0;
    tick();
    @(negedge clk);
    check("t5_pending_clear", bus.pending, 0);
    check("t5_stall_clear", bus.stall, 0);

    // Reset with three queued entries discards them.
    tick(); bus.chk_rd = 0; bus.chk_ra1 = 9;
    bus.lu_issue = 1; bus.lu_issue_rd = 9;
    pipe(5'd1, 32'h11); lu(5'd9, 32'h900);
    tick(); bus.lu_issue = 0; pipe(5'd2, 32'h12); lu(5'd22, 32'h922);
    tick(); pipe(5'd3, 32'h13); lu(5'd23, 32'h923);
    @(negedge clk);
    check("t6_stall_before_rst", bus.stall, 1);
    tick(); rst = 1; bus.p_we = 0; bus.lu_valid = 0;
    @(negedge clk);
    check("t6_rst_rf_we", bus.rf_we, 0);
    check("t6_rst_stall", bus.stall, 0);
    check("t6_rst_lu_ready", bus.lu_ready, 0);
    tick(); rst = 0;
    @(negedge clk);
    check("t6_pending_cleared", bus.pending, 0);
    check("t6_no_stale_write", bus.rf_we, 0);
    check("t6_drain_req", bus.drain_req, 0);
    repeat (4) tick();
    @(negedge clk);
    check("exp_queue_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
